// File: rtl/ram_rmw_engine_pkg.sv
// Shared types and timing constants for the RAM read-modify-write engine.
package rmw_pkg;

  localparam int STATE_W  = 3;
  localparam int RD_LAT   = 1;
  localparam int WR_DELAY = 1;
  localparam int WAIT_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_rmw_engine_addr_gen.sv
// Address and word counter for one sweep: loads base/count, steps once per word,
// wraps the address at the array depth and flags the final word.
module rmw_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  last
);

  logic [ADDR_WIDTH:0] remaining;

  assign next_addr = addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign last      = (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= count;
    end else if (step) begin
      addr      <= next_addr;
      remaining <= remaining - {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ram_rmw_engine.sv
// Sweeps count words from base_addr through the single-port RAM, adding increment to each.
// Define RMW_SATURATE_EN for an unsigned saturating add instead of a wrapping one.
module ram_rmw_engine
  import rmw_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [DATA_WIDTH-1:0] increment,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr_0,
  output logic                  ren_0,
  input  logic [DATA_WIDTH-1:0] rdata_0,
  output logic [ADDR_WIDTH-1:0] waddr_0,
  output logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  wen_0
);

  localparam logic [WAIT_W-1:0] RD_WAIT = WAIT_W'(RD_LAT - 1);
  localparam logic [WAIT_W-1:0] DR_WAIT = WAIT_W'(WR_DELAY - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   inc_q;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    ag_load;
  logic                    ag_step;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    last_word;
  logic [DATA_WIDTH-1:0]   sum_val;

  assign ag_load = (state == IDLE) && start;
  assign ag_step = (state == WRITE);

  rmw_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .step      (ag_step),
    .base      (base_addr),
    .count     (count),
    .addr      (cur_addr),
    .next_addr (nxt_addr),
    .last      (last_word)
  );

  // rdata_0 is already a RAM register, so the add feeds the write port directly.
`ifdef RMW_SATURATE_EN
  logic [DATA_WIDTH:0] wide_sum;
  always_comb begin
    wide_sum = {1'b0, rdata_0} + {1'b0, inc_q};
    sum_val  = wide_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : wide_sum[DATA_WIDTH-1:0];
  end
`else
  always_comb begin
    sum_val = rdata_0 + inc_q;
  end
`endif

  assign wdata_0 = wen_0 ? sum_val : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ren_0    <= 1'b0;
      wen_0    <= 1'b0;
      raddr_0  <= '0;
      waddr_0  <= '0;
      inc_q    <= '0;
      wait_cnt <= '0;
    end else begin
      done  <= 1'b0;
      ren_0 <= 1'b0;
      wen_0 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            inc_q <= increment;
            busy  <= 1'b1;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= READ;
              ren_0    <= 1'b1;
              raddr_0  <= base_addr;
              wait_cnt <= RD_WAIT;
            end
          end
        end
        READ: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            state   <= WRITE;
            wen_0   <= 1'b1;
            waddr_0 <= cur_addr;
          end
        end
        WRITE: begin
          if (last_word) begin
            state    <= DRAIN;
            wait_cnt <= DR_WAIT;
          end else begin
            state    <= READ;
            ren_0    <= 1'b1;
            raddr_0  <= nxt_addr;
            wait_cnt <= RD_WAIT;
          end
        end
        // Holds off done until the RAM's delayed write has reached the array.
        DRAIN: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rmw_engine.sv
// Self-checking bench for ram_rmw_engine with a registered-read, delayed-write RAM model.
// Expected results follow the RMW_SATURATE_EN build setting.
module tb_ram_rmw_engine;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] increment = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr_0;
  logic          ren_0;
  logic [DW-1:0] rdata_0 = '0;
  logic [AW-1:0] waddr_0;
  logic [DW-1:0] wdata_0;
  logic          wen_0;

  ram_rmw_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .increment (increment),
    .busy      (busy),
    .done      (done),
    .raddr_0   (raddr_0),
    .ren_0     (ren_0),
    .rdata_0   (rdata_0),
    .waddr_0   (waddr_0),
    .wdata_0   (wdata_0),
    .wen_0     (wen_0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data registered, writes pass through one delay stage.
  logic [DW-1:0] ram [DEPTH] = '{default: '0};
  logic          wen_q = 1'b0;
  logic [AW-1:0] waddr_q = '0;
  logic [DW-1:0] wdata_q = '0;
  logic          dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;

  always @(posedge clk) begin
    if (ren_0) rdata_0 <= ram[raddr_0];
    wen_q   <= wen_0;
    waddr_q <= waddr_0;
    wdata_q <= wdata_0;
    if (wen_q) ram[waddr_q] <= wdata_q;
    if (dbg_we) ram[dbg_addr] <= dbg_wdata;
  end

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] model_mem [DEPTH] = '{default: '0};
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  logic checking    = 1'b0;
  logic sweep_valid = 1'b0;
  logic exp_busy;
  int   sweep_k = 0;
  int   done_cyc = 0;
  int   exp_n = 0;
  int   ren_count = 0, wen_count = 0, done_count = 0, last_done_at = 0;
  int   ren_base = 0, wen_base = 0, done_base = 0;

  function automatic logic [DW-1:0] addModel(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef RMW_SATURATE_EN
    if (s[DW]) return '1;
`endif
    return s[DW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic syncNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic debugWrite(input logic [AW-1:0] a, input logic [DW-1:0] v);
    dbg_we = 1'b1;
    dbg_addr = a;
    dbg_wdata = v;
    model_mem[a] = v;
    syncNeg();
    dbg_we = 1'b0;
  endtask

  // Caller is just past a negedge; start is sampled at the following posedge.
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] n, input logic [DW-1:0] inc);
    logic [AW-1:0] a;
    start = 1'b1;
    base_addr = b;
    count = n;
    increment = inc;
    sweep_k = cyc;
    exp_n = int'(n);
    done_cyc = (n == 0) ? cyc + 1 : cyc + 2 * int'(n) + 2;
    ren_base = ren_count;
    wen_base = wen_count;
    done_base = done_count;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      rd_q.push_back(a);
      model_mem[a] = addModel(model_mem[a], inc);
      wr_addr_q.push_back(a);
      wr_data_q.push_back(model_mem[a]);
      a = a + 1'b1;
    end
    sweep_valid = 1'b1;
    syncNeg();
    start = 1'b0;
  endtask

  task automatic waitSweep();
    while (cyc <= done_cyc) @(negedge clk);
    #1;
    checkOutput("done_pulses", 32'(done_count - done_base), 32'd1);
    checkOutput("read_pulses", 32'(ren_count - ren_base), 32'(exp_n));
    checkOutput("write_pulses", 32'(wen_count - wen_base), 32'(exp_n));
    checkOutput("done_cycle", 32'(last_done_at), 32'(done_cyc));
    for (int a = 0; a < DEPTH; a++)
      checkOutput($sformatf("mem[%0d]", a), ram[a], model_mem[a]);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      exp_busy = sweep_valid && (cyc > sweep_k) && (cyc <= done_cyc);
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("done", 32'(done), 32'(sweep_valid && (cyc == done_cyc)));
      checkOutput("ren_wen_exclusive", 32'(ren_0 & wen_0), 32'd0);
      if (done) begin
        done_count++;
        last_done_at = cyc;
      end
      if (ren_0) begin
        ren_count++;
        if (rd_q.size() == 0) checkOutput("unexpected_read", 32'd1, 32'd0);
        else checkOutput("raddr", 32'(raddr_0), 32'(rd_q.pop_front()));
      end
      if (wen_0) begin
        wen_count++;
        if (wr_addr_q.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
        else begin
          checkOutput("waddr", 32'(waddr_0), 32'(wr_addr_q.pop_front()));
          checkOutput("wdata", wdata_0, wr_data_q.pop_front());
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_ren"}, 32'(ren_0), 32'd0);
    checkOutput({tag, "_wen"}, 32'(wen_0), 32'd0);
    checkOutput({tag, "_raddr"}, 32'(raddr_0), 32'd0);
    checkOutput({tag, "_waddr"}, 32'(waddr_0), 32'd0);
    checkOutput({tag, "_wdata"}, wdata_0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) syncNeg();
    checkIdleOutputs("reset");
    rst = 1'b1;
    checking = 1'b1;
    syncNeg();

    // single word
    debugWrite(5'd0, 32'd12);
    applyStimulus(5'd0, 6'd1, 32'd5);
    waitSweep();
    checkOutput("single_latency", 32'(last_done_at - sweep_k), 32'd4);
    checkOutput("single_mem0", ram[0], 32'd17);

    // wrap-around
    debugWrite(5'd30, 32'd1);
    debugWrite(5'd31, 32'd2);
    debugWrite(5'd0, 32'd3);
    debugWrite(5'd1, 32'd4);
    debugWrite(5'd29, 32'd55);
    debugWrite(5'd2, 32'd66);
    applyStimulus(5'd30, 6'd4, 32'd10);
    waitSweep();
    checkOutput("wrap_latency", 32'(last_done_at - sweep_k), 32'd10);
    checkOutput("wrap_mem30", ram[30], 32'd11);
    checkOutput("wrap_mem31", ram[31], 32'd12);
    checkOutput("wrap_mem0", ram[0], 32'd13);
    checkOutput("wrap_mem1", ram[1], 32'd14);
    checkOutput("wrap_mem29", ram[29], 32'd55);
    checkOutput("wrap_mem2", ram[2], 32'd66);

    // zero count
    applyStimulus(5'd7, 6'd0, 32'd9);
    waitSweep();
    checkOutput("zero_latency", 32'(last_done_at - sweep_k), 32'd1);

    // back-to-back, second start in the cycle after done
    debugWrite(5'd5, 32'd7);
    applyStimulus(5'd5, 6'd1, 32'd1);
    waitSweep();
    checkOutput("b2b_first", ram[5], 32'd8);
    applyStimulus(5'd5, 6'd1, 32'd1);
    waitSweep();
    checkOutput("b2b_second", ram[5], 32'd9);
    checkOutput("b2b_latency", 32'(last_done_at - sweep_k), 32'd4);

    // overflow
    debugWrite(5'd3, 32'hFFFF_FFF0);
    applyStimulus(5'd3, 6'd1, 32'h20);
    waitSweep();
`ifdef RMW_SATURATE_EN
    checkOutput("overflow_mem3", ram[3], 32'hFFFF_FFFF);
`else
    checkOutput("overflow_mem3", ram[3], 32'h0000_0010);
`endif

    // start while busy is ignored
    applyStimulus(5'd10, 6'd4, 32'd3);
    repeat (2) syncNeg();
    start = 1'b1;
    base_addr = 5'd20;
    count = 6'd2;
    increment = 32'd99;
    syncNeg();
    start = 1'b0;
    waitSweep();
    checkOutput("busy_start_latency", 32'(last_done_at - sweep_k), 32'd10);
    checkOutput("busy_start_mem10", ram[10], 32'd3);
    checkOutput("busy_start_mem20", ram[20], 32'd0);

    // reset during WRITE of word 2; that write is already in the RAM delay stage
    debugWrite(5'd12, 32'd100);
    debugWrite(5'd13, 32'd200);
    debugWrite(5'd14, 32'd300);
    debugWrite(5'd15, 32'd400);
    applyStimulus(5'd12, 6'd4, 32'd1);
    while (cyc < sweep_k + 4) syncNeg();
    rst = 1'b0;
    checking = 1'b0;
    syncNeg();
    checkIdleOutputs("abort");
    rst = 1'b1;
    sweep_valid = 1'b0;
    rd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    model_mem[14] = 32'd300;
    model_mem[15] = 32'd400;
    done_base = done_count;
    checking = 1'b1;
    repeat (4) syncNeg();
    checkOutput("abort_no_done", 32'(done_count - done_base), 32'd0);
    checkOutput("abort_mem12", ram[12], 32'd101);
    checkOutput("abort_mem13", ram[13], 32'd201);
    checkOutput("abort_mem14", ram[14], 32'd300);
    checkOutput("abort_mem15", ram[15], 32'd400);
    applyStimulus(5'd12, 6'd4, 32'd1);
    waitSweep();
    checkOutput("after_reset_mem12", ram[12], 32'd102);
    checkOutput("after_reset_mem15", ram[15], 32'd401);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
